vram_ctrl: RTL

VRAM_CTRL -- requirements
Module: vram_ctrl

---
 rtl/vram_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/vram_ctrl.sv
// ---------------------------------------------------------------------------
// vram_ctrl
//
// Time-shares a single asynchronous SRAM between the video fetch path and a
// CPU port. Every CLK cycle is a slot: clk7=1 is a video slot, clk7=0 is a
// CPU slot. Video fetches are never delayed. CPU writes are buffered and
// retired one per CPU slot in arrival order. A CPU read is held until the
// write buffer has fully drained, so a read always sees earlier writes.
//
// Build option:
//   VRAM_WRITE_FIFO_EN  defined   -> write buffer is a FIFO_DEPTH-entry FIFO
//                       undefined -> write buffer is a single holding register
//
// Parameters:
//   FIFO_DEPTH   write FIFO entries (power of 2, 2..16)
//
// Ports:
//   CLK          14 MHz master clock
//   RESET        asynchronous active-high reset
//   clk7         pixel-clock level, 1 = video slot
//   vram_addr    video fetch address (13 bits)
//   vram_dout    video fetch data, updated at the end of each video slot
//   vid_page     shadow-screen select (0 = bank 5, 1 = bank 7)
//   cpu_we       one-cycle write strobe
//   cpu_rd       one-cycle read strobe
//   cpu_addr     {bank bit, 13-bit offset}
//   cpu_din      CPU write data
//   cpu_dout     CPU read data
//   cpu_rvalid   one-cycle read-complete pulse
//   cpu_wait     write buffer full or read pending
//   sram_addr    SRAM address
//   sram_din     SRAM write data
//   sram_dout    SRAM read data (combinational from sram_addr)
//   sram_we      SRAM write enable, active high
//
// Internal status: overflow_err_q is a sticky flag set when a write is
// dropped because the buffer was full.
// ---------------------------------------------------------------------------
module vram_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        clk7,
   input  logic [12:0] vram_addr,
   output logic [7:0]  vram_dout,
   input  logic        vid_page,
   input  logic        cpu_we,
   input  logic        cpu_rd,
   input  logic [13:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_rvalid,
   output logic        cpu_wait,
   output logic [13:0] sram_addr,
   output logic [7:0]  sram_din,
   input  logic [7:0]  sram_dout,
   output logic        sram_we
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef VRAM_WRITE_FIFO_EN
   localparam int DEPTH = FIFO_DEPTH;
`else
   localparam int DEPTH = 1;
`endif
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // registered state
   logic [CW-1:0] count_q, count_d;
   logic          rd_pend_q, rd_pend_d;
   logic [13:0]   rd_addr_q, rd_addr_d;
   logic [7:0]    vram_dout_q, vram_dout_d;
   logic [7:0]    cpu_dout_q, cpu_dout_d;
   logic          cpu_rvalid_q, cpu_rvalid_d;
   logic          overflow_err_q, overflow_err_d;
   logic [13:0]   last_addr_q, last_addr_d;
   logic [7:0]    last_din_q, last_din_d;

   // slot decode and buffer control
   logic          fifo_empty;
   logic          fifo_full;
   logic          do_pop;
   logic          do_read;
   logic          do_push;
   logic [13:0]   head_addr;
   logic [7:0]    head_data;

   // unguarded SRAM drive, before the reset override
   logic [13:0]   sram_addr_c;
   logic [7:0]    sram_din_c;
   logic          sram_we_c;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == DEPTH_C);

   // A CPU slot services the write buffer first; a read only goes out once
   // the buffer is empty, which gives read-after-write ordering for free.
   assign do_pop  = ~clk7 & ~fifo_empty;
   assign do_read = ~clk7 & fifo_empty & rd_pend_q;

   // A pop in the same cycle frees the slot the push needs.
   assign do_push = cpu_we & (~fifo_full | do_pop);

   // -----------------------------------------------------------------------
   // Write buffer storage
   // -----------------------------------------------------------------------
`ifdef VRAM_WRITE_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [21:0]   fifo_mem [DEPTH];

   // Pointers are exactly log2(depth) wide, so increments wrap on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry contents need no reset: occupancy decides what is valid.
   always_ff @(posedge CLK) begin
      if (do_push) fifo_mem[wr_ptr_q] <= {cpu_addr, cpu_din};
   end

   assign head_addr = fifo_mem[rd_ptr_q][21:8];
   assign head_data = fifo_mem[rd_ptr_q][7:0];
`else
   logic [21:0] hold_q;

   always_ff @(posedge CLK) begin
      if (do_push) hold_q <= {cpu_addr, cpu_din};
   end

   assign head_addr = hold_q[21:8];
   assign head_data = hold_q[7:0];
`endif

   // -----------------------------------------------------------------------
   // SRAM port multiplexing
   // -----------------------------------------------------------------------
   always_comb begin
      sram_addr_c = last_addr_q;
      sram_din_c  = last_din_q;
      sram_we_c   = 1'b0;
      if (clk7) begin
         sram_addr_c = {vid_page, vram_addr};
      end else if (do_pop) begin
         sram_addr_c = head_addr;
         sram_din_c  = head_data;
         sram_we_c   = 1'b1;
      end else if (do_read) begin
         sram_addr_c = rd_addr_q;
      end
   end

   // Reset has to silence the bus at once, not at the next edge, so the
   // outputs are gated combinationally as well as the state being cleared.
   always_comb begin
      sram_addr = sram_addr_c;
      sram_din  = sram_din_c;
      sram_we   = sram_we_c;
      if (RESET) begin
         sram_addr = '0;
         sram_din  = '0;
         sram_we   = 1'b0;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      count_d        = count_q + CW'(do_push) - CW'(do_pop);
      rd_pend_d      = rd_pend_q;
      rd_addr_d      = rd_addr_q;
      vram_dout_d    = vram_dout_q;
      cpu_dout_d     = cpu_dout_q;
      cpu_rvalid_d   = do_read;
      overflow_err_d = overflow_err_q | (cpu_we & ~do_push);
      last_addr_d    = sram_addr_c;
      last_din_d     = sram_din_c;

      if (clk7) vram_dout_d = sram_dout;
      if (do_read) begin
         cpu_dout_d = sram_dout;
         rd_pend_d  = 1'b0;
      end
      // Only one read may be outstanding; further strobes are ignored.
      if (cpu_rd && !rd_pend_q) begin
         rd_pend_d = 1'b1;
         rd_addr_d = cpu_addr;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count_q        <= '0;
         rd_pend_q      <= 1'b0;
         rd_addr_q      <= '0;
         vram_dout_q    <= '0;
         cpu_dout_q     <= '0;
         cpu_rvalid_q   <= 1'b0;
         overflow_err_q <= 1'b0;
         last_addr_q    <= '0;
         last_din_q     <= '0;
      end else begin
         count_q        <= count_d;
         rd_pend_q      <= rd_pend_d;
         rd_addr_q      <= rd_addr_d;
         vram_dout_q    <= vram_dout_d;
         cpu_dout_q     <= cpu_dout_d;
         cpu_rvalid_q   <= cpu_rvalid_d;
         overflow_err_q <= overflow_err_d;
         last_addr_q    <= last_addr_d;
         last_din_q     <= last_din_d;
      end
   end

   assign vram_dout  = vram_dout_q;
   assign cpu_dout   = cpu_dout_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign cpu_wait   = fifo_full | rd_pend_q;

endmodule
